bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
//
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) that
//   consumes the WIDTH-bit count value produced by the counter stage.
//   It produces packed BCD digits for the 7-segment/hex display path.
//   A start/busy/done handshake is used, so the counter can keep running while
//   a captured snapshot is converted. One conversion takes WIDTH shift cycles.
//
// PARAMETERS
//   WIDTH   8   bit width of binary input (matches counter WIDTH)
//   DIGITS  3   number of BCD digits output; must satisfy 10**DIGITS > 2**WIDTH-1
//
// PORTS
//   clk    in   1           system clock, all state updates on posedge
//   rst    in   1           asynchronous, active-high reset
//   start  in   1           request conversion of bin; sampled on posedge clk
//   bin    in   WIDTH       binary value; captured only on an accepted start
//   busy   out  1           high while shift iterations are in progress
//   done   out  1           single-cycle pulse: bcd holds a fresh result
//   bcd    out  4*DIGITS    packed BCD result; digit k at bcd[4k+3:4k], k=0 is units
//
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, busy=0, done=0, bcd=0, internal scratch/iter cleared.
//     Reset mid-conversion aborts it; no done pulse is produced; bcd reads 0.
//   - FSM states: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE).
//   - IDLE: start=1 at edge E0 -> capture bin into shift reg, clear BCD scratch,
//     iter=0, go SHIFT. start=0 -> stay.
//   - SHIFT: each edge, for every scratch digit >= 5 add 3 (4-bit, no carry
//     between digits), then shift {scratch,shiftreg} left 1, iter++.
//     At edge E_WIDTH (last iteration) load bcd <= final scratch, go DONE.
//   - DONE: lasts exactly one cycle (done=1, bcd valid). Next edge: start=1 ->
//     accept new conversion as from IDLE (back-to-back); else -> IDLE.
//   - start while SHIFT is ignored (no restart, no queuing).
//   - Latency: start sampled at E0 -> done high in cycle after E_WIDTH.
//     Throughput: one conversion per WIDTH+1 cycles.
//   - bcd holds the last completed result until the next DONE or reset;
//     it never shows intermediate scratch values.
//   - bin changes after capture have no effect on the running conversion.
//   - iter counter width = clog2(WIDTH+1); no other arithmetic beyond per-digit +3.
//   - Input 2**WIDTH-1 must convert exactly; scratch never overflows for legal DIGITS.
//
// TESTING
//   1. rst pulse asynchronously (no clk edge) -> busy=0, done=0, bcd=12'h000 immediately.
//   2. bin=8'd255, start 1 cycle -> busy for 8 cycles, done pulse 1 cycle, bcd=12'h255.
//   3. bin=8'd0 then bin=8'd99 -> bcd=12'h000, then 12'h099; done once per conversion.
//   4. start=1 held during SHIFT with bin changing to 8'd7 -> ignored, result of the
//      captured value (e.g. 8'd128 -> 12'h128); then start held in DONE -> 12'h007,
//      next done exactly 9 cycles after previous.
//   5. rst asserted at iteration 4 of bin=8'd200 -> no done pulse, bcd=0, IDLE;
//      a fresh start yields 12'h200.
//   6. Exhaustive sweep bin=0..255 driven from the counter stage -> every bcd matches
//      model (d2*100+d1*10+d0 == bin, all digits <= 9).

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between the counter stage (master) and
// the sequential binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  // Requester: issues start with a value, watches busy/done and reads bcd.
  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
  );

  // Converter: samples start/bin, reports progress and the result.
  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// A snapshot of bin is taken on an accepted start and converted over WIDTH
// shift cycles; the result is published on bcd together with a one-cycle
// done pulse. bcd only ever shows completed results (or zero after reset).
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam int BCD_W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Add 3 to every BCD digit that is 5 or more; digits are independent,
  // so no carry ever crosses a nibble boundary.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = s[4*k +: 4];
      end
    end
    return r;
  endfunction

  state_t                state;
  logic [WIDTH-1:0]      shift_reg;
  logic [BCD_W-1:0]      scratch;
  logic [ITER_W-1:0]     iter;
  logic [BCD_W-1:0]      bcd_result;
  logic                  busy_flag;
  logic                  done_flag;

  logic [BCD_W-1:0]      adjusted;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [BCD_W-1:0]      scratch_next;
  logic [WIDTH-1:0]      shift_next;
  logic                  last_iter;

  // One double-dabble step: correct digits, then shift {scratch,shift_reg} left.
  always_comb begin
    adjusted     = add3_digits(scratch);
    shifted      = {adjusted, shift_reg} << 1;
    scratch_next = shifted[BCD_W+WIDTH-1:WIDTH];
    shift_next   = shifted[WIDTH-1:0];
    if (iter == ITER_W'(WIDTH - 1)) begin
      last_iter = 1'b1;
    end else begin
      last_iter = 1'b0;
    end
  end

  // Control FSM with registered busy/done/bcd; DONE may chain straight into
  // a new conversion so back-to-back throughput is one result per WIDTH+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= {WIDTH{1'b0}};
      scratch    <= {BCD_W{1'b0}};
      iter       <= {ITER_W{1'b0}};
      bcd_result <= {BCD_W{1'b0}};
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= SHIFT;
            shift_reg <= bus.bin;
            scratch   <= {BCD_W{1'b0}};
            iter      <= {ITER_W{1'b0}};
            busy_flag <= 1'b1;
            done_flag <= 1'b0;
          end else begin
            state     <= IDLE;
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here: no restart, no queuing.
          shift_reg <= shift_next;
          scratch   <= scratch_next;
          iter      <= iter + ITER_W'(1);
          if (last_iter) begin
            state      <= DONE;
            bcd_result <= scratch_next;
            busy_flag  <= 1'b0;
            done_flag  <= 1'b1;
          end else begin
            state     <= SHIFT;
            busy_flag <= 1'b1;
            done_flag <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy_flag <= 1'b0;
          done_flag <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_flag;
  assign bus.done = done_flag;
  assign bus.bcd  = bcd_result;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake scenarios, an
// exhaustive sweep and random values, checked against a decimal-arithmetic
// reference model.
module tb_bin2bcd_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'(v / 100);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one conversion, measure busy length, check result and single done.
  task automatic convert(input logic [7:0] v, input string tag, input bit full);
    int busy_cnt;
    bit got_done;
    logic [11:0] obs;
    int d0, d1, d2;
    busy_cnt = 0;
    got_done = 1'b0;
    @(negedge clk);
    bus.bin   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 8'($urandom);
    for (int i = 0; i < 30 && !got_done; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) got_done = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
    obs = bus.bcd;
    check({tag, "_bcd"}, {20'd0, obs}, {20'd0, ref_bcd(int'(v))});
    if (full) begin
      d0 = int'(obs[3:0]); d1 = int'(obs[7:4]); d2 = int'(obs[11:8]);
      check({tag, "_digits_le9"}, {31'd0, (d0 <= 9 && d1 <= 9 && d2 <= 9)}, 32'd1);
      check({tag, "_weighted"}, 32'(d2 * 100 + d1 * 10 + d0), {24'd0, v});
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
      @(negedge clk);
      check({tag, "_done_single"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_bcd_hold"}, {20'd0, bus.bcd}, {20'd0, ref_bcd(int'(v))});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    bit seen;
    int done_cnt;
    n_checks = 0;
    n_pass   = 0;
    bus.start = 1'b0;
    bus.bin   = 8'd0;
    rst = 1'b1;
    #12;
    // 1. reset state
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_bcd", {20'd0, bus.bcd}, 32'h000);
    @(negedge clk);
    rst = 1'b0;

    // 2. max value
    convert(8'd255, "max", 1'b1);
    // 3. zero then 99
    convert(8'd0, "zero", 1'b1);
    convert(8'd99, "n99", 1'b1);

    // 4. start held through SHIFT with bin changing; back-to-back from DONE
    @(negedge clk);
    bus.bin   = 8'd128;
    bus.start = 1'b1;
    @(negedge clk);
    bus.bin = 8'd7;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    check("hold_first_done", {31'd0, seen}, 32'd1);
    check("hold_first_bcd", {20'd0, bus.bcd}, {20'd0, ref_bcd(128)});
    @(negedge clk);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    gap  = 1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        gap++;
      end
    end
    check("b2b_done", {31'd0, seen}, 32'd1);
    check("b2b_gap", 32'(gap), 32'd9);
    check("b2b_bcd", {20'd0, bus.bcd}, {20'd0, ref_bcd(7)});

    // 5. reset during iteration 4 of 200
    @(negedge clk);
    bus.bin   = 8'd200;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_bcd", {20'd0, bus.bcd}, 32'h000);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("abort_idle", 32'(done_cnt), 32'd0);
    check("abort_bcd_held", {20'd0, bus.bcd}, 32'h000);
    convert(8'd200, "after_abort", 1'b1);

    // 6. exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), "sweep", 1'b0);
    end

    // random values with full timing checks
    for (int i = 0; i < 40; i++) begin
      convert(8'($urandom_range(255, 0)), "rand", 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
